// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM state type for the radix-2 divider
//
// Contents:
//   DIV_WIDTH    default operand/result width
//   DIV_CNT_W    iteration counter width for the default width
//   div_state_e  controller states IDLE, PREP, ITER, FIX
package div_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_substep.sv
// rtl/div_substep.sv - one combinational non-restoring division iteration
//
// Ports:
//   p_i  [WIDTH:0]    partial remainder, two's complement
//   q_i  [WIDTH-1:0]  dividend bits still to shift in / quotient bits so far
//   d_i  [WIDTH-1:0]  divisor magnitude
//   p_o  [WIDTH:0]    next partial remainder
//   q_o  [WIDTH-1:0]  next quotient register, new bit in the LSB
module div_substep
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] p_shift;

    // The add/subtract choice uses the sign before the shift. The shift may
    // wrap for large divisors, but the sum lands back in [-D, D), which fits,
    // so modular arithmetic yields the exact partial remainder.
    assign p_shift = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign p_o     = p_i[WIDTH] ? (p_shift + {1'b0, d_i})
                                : (p_shift - {1'b0, d_i});
    assign q_o     = {q_i[WIDTH-2:0], ~p_o[WIDTH]};

endmodule

// File: rtl/radix2_divider.sv
// rtl/radix2_divider.sv - sequential non-restoring radix-2 divider, one quotient bit per clock
//
// Optional feature macro: DIVIDER_SIGNED_EN (two's-complement signed operands
// and results); when undefined the divider is unsigned only.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   quotient     result, held until overwritten by a later completion
//   remainder    result, held until overwritten by a later completion
//   div_by_zero  set with done when the divisor was zero
module radix2_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIVIDER_SIGNED_EN
    // negq: quotient must be negated; negr: dividend was negative.
    // Their XOR recovers the divisor sign, so it needs no register of its own.
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    logic [WIDTH:0]   step_p;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] rem_fix;

    div_substep #(
        .WIDTH(WIDTH)
    ) u_substep (
        .p_i(p_q),
        .q_i(q_q),
        .d_i(d_q),
        .p_o(step_p),
        .q_o(step_q)
    );

    // Final remainder correction; the corrected value lies in [0, D) so the
    // low WIDTH bits are the whole answer.
    assign rem_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d  = dividend[WIDTH-1];
`endif
                    state_d = PREP;
                end
            end
            PREP: begin
                if (d_q == '0) begin
                    // q_q still holds the raw dividend here.
                    quo_d   = '1;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
`ifdef DIVIDER_SIGNED_EN
                    q_d     = negr_q ? (-q_q) : q_q;
                    d_d     = (negq_q ^ negr_q) ? (-d_q) : d_q;
`endif
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
`ifdef DIVIDER_SIGNED_EN
                // The most-negative / -1 case wraps naturally through the negation.
                quo_d = negq_q ? (-q_q) : q_q;
                rem_d = negr_q ? (-rem_fix) : rem_fix;
`else
                quo_d = q_q;
                rem_d = rem_fix;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_radix2_divider.sv
// tb/tb_radix2_divider.sv - scoreboard testbench for radix2_divider
module tb_radix2_divider;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    radix2_divider #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("done_single_cycle", W'(prev_done), W'(0));
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_quotient"}, quotient, e.q);
                chk({e.name, "_remainder"}, remainder, e.r);
                chk({e.name, "_div_by_zero"}, W'(div_by_zero), W'(e.dz));
                chk({e.name, "_done_edge"}, W'(cyc - e.acc), W'(e.lat));
                chk({e.name, "_busy_low"}, W'(busy), W'(0));
            end
        end
        prev_done = done;
    end

    // Called at a negedge; the following posedge accepts the request.
    task automatic drive_now(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                             input int lat);
        exp_t e;
        e.name = name;
        e.q    = q;
        e.r    = r;
        e.dz   = dz;
        e.acc  = cyc + 1;
        e.lat  = lat;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_busy_after_accept"}, W'(busy), W'(1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                         input int lat);
        @(negedge clk);
        drive_now(name, a, b, q, r, dz, lat);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                       input int lat);
        issue(name, a, b, q, r, dz, lat);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_quotient"}, quotient, W'(0));
        chk({tag, "_remainder"}, remainder, W'(0));
        chk({tag, "_div_by_zero"}, W'(div_by_zero), W'(0));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

`ifdef DIVIDER_SIGNED_EN
        run("s_100_7",     64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66);
        run("s_m100_7",    64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
            64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run("s_100_m7",    64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
            64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 66);
        run("s_m100_m7",   64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
            64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run("s_5_0",       64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1);
        run("s_min_m1",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0, 1'b0, 66);
        run("s_3_10",      64'd3, 64'd10, 64'd0, 64'd3, 1'b0, 66);
        run("s_m3_10",     64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66);
        run("s_min_2",     64'h8000_0000_0000_0000, 64'd2,
            64'hC000_0000_0000_0000, 64'd0, 1'b0, 66);
`else
        run("u_100_7",     64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66);
        run("u_5_0",       64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1);
        run("u_max_2",     64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
            64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 66);
        run("u_1000_1000", 64'd1000, 64'd1000, 64'd1, 64'd0, 1'b0, 66);
        run("u_3_10",      64'd3, 64'd10, 64'd0, 64'd3, 1'b0, 66);
        run("u_max_max",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd1, 64'd0, 1'b0, 66);
        run("u_msb_max",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd0, 64'h8000_0000_0000_0000, 1'b0, 66);
        run("u_shift16",   64'h1234_5678_9ABC_DEF0, 64'h10,
            64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 66);
`endif

        // Start while busy is ignored; start in the done cycle is accepted.
        issue("first", 64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 66);
        repeat (9) @(posedge clk);
        #1;
        dividend = 64'd50;
        divisor  = 64'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 64'd12345;
        divisor  = 64'd0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL first_done_timeout: got no done expected done within 200 cycles");
        end
        drive_now("second", 64'd77, 64'd8, 64'd9, 64'd5, 1'b0, 66);
        wait_drain();

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        dividend = 64'd999;
        divisor  = 64'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", 64'd81, 64'd9, 64'd9, 64'd0, 1'b0, 66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
